// File: rtl/bsg_flow_pkg.sv
// rtl/bsg_flow_pkg.sv - shared width helpers for the valid/credit receive path
package bsg_flow_pkg;

   localparam int default_width_c = 128;
   localparam int default_els_c   = 8;

   function automatic int ptr_width(input int els);
      return (els > 1) ? $clog2(els) : 1;
   endfunction

   function automatic int count_width(input int els);
      return $clog2(els + 1);
   endfunction

   function automatic int credit_width(input int decimation);
      return (decimation > 1) ? $clog2(decimation + 1) : 1;
   endfunction

endpackage

// File: rtl/bsg_flow_credit_fifo.sv
// rtl/bsg_flow_credit_fifo.sv - els_p deep buffer with wrapping pointers and occupancy
// Head word is presented combinationally from storage; no bypass path.
module bsg_flow_credit_fifo
   import bsg_flow_pkg::*;
#(
   parameter int width_p = default_width_c,
   parameter int els_p   = default_els_c
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          v_i,
   input  logic [width_p-1:0]            data_i,
   input  logic                          yumi_i,
   output logic                          v_o,
   output logic [width_p-1:0]            data_o,
   output logic                          full_o,
   output logic                          accept_o,
   output logic [count_width(els_p)-1:0] count_o
);

   localparam int ptr_w_lp = ptr_width(els_p);
   localparam int cnt_w_lp = count_width(els_p);

   logic [width_p-1:0]  mem_r [els_p];
   logic [ptr_w_lp-1:0] wptr_r;
   logic [ptr_w_lp-1:0] rptr_r;
   logic [cnt_w_lp-1:0] count_r;
   logic                deq;

   function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
   endfunction

   assign v_o      = (count_r != '0);
   assign full_o   = (count_r == cnt_w_lp'(els_p));
   assign deq      = yumi_i & v_o;
   // A slot freed by this cycle's dequeue may be refilled at the same edge.
   assign accept_o = v_i & (~full_o | deq);
   assign data_o   = mem_r[rptr_r];
   assign count_o  = count_r;

   always_ff @(posedge clk_i) begin
      if (accept_o) begin
         mem_r[wptr_r] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (accept_o) begin
            wptr_r <= ptr_inc(wptr_r);
         end
         if (deq) begin
            rptr_r <= ptr_inc(rptr_r);
         end
         case ({accept_o, deq})
            2'b10:   count_r <= count_r + cnt_w_lp'(1);
            2'b01:   count_r <= count_r - cnt_w_lp'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/bsg_flow_credit_receiver.sv
// rtl/bsg_flow_credit_receiver.sv - credit-link receiver: buffer, credit return, overflow flag
// Credits leave one cycle after the dequeue that completes a decimation group.
module bsg_flow_credit_receiver
   import bsg_flow_pkg::*;
#(
   parameter int width_p             = default_width_c,
   parameter int els_p               = default_els_c,
   parameter int credit_decimation_p = 1,
   parameter bit assert_overflow_p   = 1'b1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               credit_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               ready_i,
   output logic               overflow_o
);

   localparam int cred_w_lp = credit_width(credit_decimation_p);
   localparam int cnt_w_lp  = count_width(els_p);
   localparam logic [cred_w_lp-1:0] cred_last_lp = cred_w_lp'(credit_decimation_p - 1);

   typedef struct packed {
      logic               v;
      logic [width_p-1:0] data;
   } link_s;

   link_s               link_in;
   logic                full;
   logic                accept;
   logic                deq;
   logic [cnt_w_lp-1:0] count;
   logic [cred_w_lp-1:0] cred_acc_r;
   logic                credit_r;
   logic                overflow_r;

   assign link_in = '{v: v_i, data: data_i};
   assign deq     = v_o & ready_i;

   bsg_flow_credit_fifo #(
      .width_p (width_p),
      .els_p   (els_p)
   ) fifo (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .v_i      (link_in.v),
      .data_i   (link_in.data),
      .yumi_i   (ready_i),
      .v_o      (v_o),
      .data_o   (data_o),
      .full_o   (full),
      .accept_o (accept),
      .count_o  (count)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cred_acc_r <= '0;
         credit_r   <= 1'b0;
      end else if (deq && (cred_acc_r == cred_last_lp)) begin
         cred_acc_r <= '0;
         credit_r   <= 1'b1;
      end else if (deq) begin
         cred_acc_r <= cred_acc_r + cred_w_lp'(1);
         credit_r   <= 1'b0;
      end else begin
         credit_r   <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         overflow_r <= 1'b0;
      end else if (link_in.v && !accept) begin
         overflow_r <= 1'b1;
      end
   end

   assign credit_o   = credit_r;
   assign overflow_o = overflow_r;

   if ((els_p % credit_decimation_p) != 0) begin : g_bad_decimation
      $error("els_p must be a multiple of credit_decimation_p");
   end
   if (els_p < 2) begin : g_bad_els
      $error("els_p must be at least 2");
   end

   if (assert_overflow_p) begin : g_overflow_check
      a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
         !(link_in.v && !accept));
   end

   a_count_bound: assert property (@(posedge clk_i) disable iff (reset_i)
      count <= cnt_w_lp'(els_p));

endmodule

// File: tb/tb_bsg_flow_credit_receiver.sv
// tb/tb_bsg_flow_credit_receiver.sv - scoreboard bench for the credit receiver
module tb_bsg_flow_credit_receiver;

   localparam int W   = 16;
   localparam int ELS = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset_i = 1'b1;
   logic         v_i     = 1'b0;
   logic         ready_i = 1'b0;
   logic [W-1:0] data_i  = '0;
   logic         credit_o, v_o, overflow_o;
   logic [W-1:0] data_o;
   logic         credit4, v4, ovf4;
   logic [W-1:0] data4;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [W-1:0] sb [$];
   int           m_cnt      = 0;
   int           m_deqs     = 0;
   logic         m_prev_deq = 1'b0;
   logic         m_ovf      = 1'b0;

   logic         s_v, s_c1, s_c4, s_ovf;
   logic [W-1:0] s_data;
   logic         exp_v, exp_c1, exp_c4, exp_ovf, did_deq;
   logic [W-1:0] exp_data;

   bsg_flow_credit_receiver #(
      .width_p (W), .els_p (ELS), .credit_decimation_p (1), .assert_overflow_p (1'b0)
   ) dut (
      .clk_i (clk), .reset_i (reset_i), .v_i (v_i), .data_i (data_i),
      .credit_o (credit_o), .v_o (v_o), .data_o (data_o),
      .ready_i (ready_i), .overflow_o (overflow_o)
   );

   bsg_flow_credit_receiver #(
      .width_p (W), .els_p (ELS), .credit_decimation_p (4), .assert_overflow_p (1'b0)
   ) dut4 (
      .clk_i (clk), .reset_i (reset_i), .v_i (v_i), .data_i (data_i),
      .credit_o (credit4), .v_o (v4), .data_o (data4),
      .ready_i (ready_i), .overflow_o (ovf4)
   );

   // One cycle: drive inputs, sample at negedge, then advance the reference model.
   task automatic tick(input logic v, input logic [W-1:0] d, input logic r, input logic rst);
      bit enq;
      v_i = v; data_i = d; ready_i = r; reset_i = rst;
      exp_v   = (m_cnt != 0);
      exp_c1  = m_prev_deq;
      exp_c4  = m_prev_deq && ((m_deqs % 4) == 0);
      exp_ovf = m_ovf;
      did_deq = exp_v && r;
      if (did_deq) exp_data = sb.pop_front();
      @(negedge clk);
      s_v = v_o; s_data = data_o; s_c1 = credit_o; s_c4 = credit4; s_ovf = overflow_o;
      if (rst) begin
         sb.delete(); m_cnt = 0; m_deqs = 0; m_prev_deq = 1'b0; m_ovf = 1'b0;
      end else begin
         enq = v && ((m_cnt < ELS) || did_deq);
         if (v && !enq) m_ovf = 1'b1;
         if (enq) sb.push_back(d);
         m_cnt = m_cnt + int'(enq) - int'(did_deq);
         m_prev_deq = did_deq;
         if (did_deq) m_deqs++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(1'b0, '0, 1'b0, 1'b1);
      tick(1'b0, '0, 1'b0, 1'b1);
      tick(1'b0, '0, 1'b0, 1'b0);
      tests_run++; if (s_v !== 1'b0) begin tests_failed++; $display("FAIL reset_v got %b want 0", s_v); end
      tests_run++; if (s_c1 !== 1'b0) begin tests_failed++; $display("FAIL reset_credit got %b want 0", s_c1); end
      tests_run++; if (s_c4 !== 1'b0) begin tests_failed++; $display("FAIL reset_credit4 got %b want 0", s_c4); end
      tests_run++; if (s_ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b want 0", s_ovf); end
   endtask

   task automatic test_stream();
      int pulses = 0;
      for (int i = 0; i < 11; i++) begin
         tick(i < 8, W'(i), 1'b1, 1'b0);
         pulses += int'(s_c1);
         tests_run++; if (s_v !== exp_v) begin tests_failed++; $display("FAIL stream_v cyc %0d got %b want %b", i, s_v, exp_v); end
         tests_run++; if (s_c1 !== exp_c1) begin tests_failed++; $display("FAIL stream_credit cyc %0d got %b want %b", i, s_c1, exp_c1); end
         if (did_deq) begin
            tests_run++; if (s_data !== exp_data) begin tests_failed++; $display("FAIL stream_data cyc %0d got %0d want %0d", i, s_data, exp_data); end
         end
      end
      tests_run++; if (pulses != 8) begin tests_failed++; $display("FAIL stream_pulses got %0d want 8", pulses); end
   endtask

   task automatic test_fill_drain();
      int pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, W'(16 + i), 1'b0, 1'b0);
         tests_run++; if (s_c1 !== 1'b0) begin tests_failed++; $display("FAIL fill_credit cyc %0d got %b want 0", i, s_c1); end
         tests_run++; if (s_ovf !== 1'b0) begin tests_failed++; $display("FAIL fill_overflow cyc %0d got %b want 0", i, s_ovf); end
      end
      for (int i = 0; i < 9; i++) begin
         tick(1'b0, '0, 1'b1, 1'b0);
         pulses += int'(s_c1);
         tests_run++; if (s_v !== exp_v) begin tests_failed++; $display("FAIL drain_v cyc %0d got %b want %b", i, s_v, exp_v); end
         if (did_deq) begin
            tests_run++; if (s_data !== exp_data) begin tests_failed++; $display("FAIL drain_data cyc %0d got %0d want %0d", i, s_data, exp_data); end
         end
      end
      tests_run++; if (s_v !== 1'b0) begin tests_failed++; $display("FAIL drain_empty got %b want 0", s_v); end
      tick(1'b0, '0, 1'b1, 1'b0);
      pulses += int'(s_c1);
      tests_run++; if (pulses != 8) begin tests_failed++; $display("FAIL drain_pulses got %0d want 8", pulses); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i++) tick(1'b1, W'(32 + i), 1'b0, 1'b0);
      tick(1'b1, W'(99), 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      tests_run++; if (s_ovf !== 1'b1) begin tests_failed++; $display("FAIL overflow_set got %b want 1", s_ovf); end
      tests_run++; if (ovf4 !== 1'b1) begin tests_failed++; $display("FAIL overflow4_set got %b want 1", ovf4); end
      for (int i = 0; i < 9; i++) begin
         tick(1'b0, '0, 1'b1, 1'b0);
         tests_run++; if (s_v !== exp_v) begin tests_failed++; $display("FAIL ovf_drain_v cyc %0d got %b want %b", i, s_v, exp_v); end
         if (did_deq) begin
            tests_run++; if (s_data !== exp_data) begin tests_failed++; $display("FAIL ovf_drain_data cyc %0d got %0d want %0d", i, s_data, exp_data); end
         end
      end
      tests_run++; if (s_ovf !== 1'b1) begin tests_failed++; $display("FAIL overflow_sticky got %b want 1", s_ovf); end
   endtask

   task automatic test_full_passthrough();
      logic [W-1:0] last = '0;
      tick(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) tick(1'b1, W'(48 + i), 1'b0, 1'b0);
      tick(1'b1, W'(100), 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) begin
         tick(1'b0, '0, 1'b1, 1'b0);
         if (did_deq) begin
            last = s_data;
            tests_run++; if (s_data !== exp_data) begin tests_failed++; $display("FAIL pass_data cyc %0d got %0d want %0d", i, s_data, exp_data); end
         end
      end
      tests_run++; if (last !== W'(100)) begin tests_failed++; $display("FAIL pass_last got %0d want 100", last); end
      tests_run++; if (s_ovf !== 1'b0) begin tests_failed++; $display("FAIL pass_overflow got %b want 0", s_ovf); end
   endtask

   task automatic test_decimation();
      int pulses = 0;
      tick(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) tick(1'b1, W'(64 + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, '0, 1'b1, 1'b0);
         pulses += int'(s_c4);
         tests_run++; if (s_c4 !== exp_c4) begin tests_failed++; $display("FAIL dec4_credit cyc %0d got %b want %b", i, s_c4, exp_c4); end
      end
      tests_run++; if (pulses != 2) begin tests_failed++; $display("FAIL dec4_pulses got %0d want 2", pulses); end
   endtask

   task automatic test_reset_mid();
      int p1 = 0;
      int p4 = 0;
      tick(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) tick(1'b1, W'(80 + i), 1'b0, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b1);
      tick(1'b0, '0, 1'b0, 1'b0);
      tests_run++; if (s_v !== 1'b0) begin tests_failed++; $display("FAIL midreset_v got %b want 0", s_v); end
      tests_run++; if (s_c1 !== 1'b0) begin tests_failed++; $display("FAIL midreset_credit got %b want 0", s_c1); end
      tests_run++; if (s_c4 !== 1'b0) begin tests_failed++; $display("FAIL midreset_credit4 got %b want 0", s_c4); end
      tests_run++; if (s_ovf !== 1'b0) begin tests_failed++; $display("FAIL midreset_overflow got %b want 0", s_ovf); end
      for (int i = 0; i < 11; i++) begin
         tick(i < 8, W'(200 + i), 1'b1, 1'b0);
         p1 += int'(s_c1);
         p4 += int'(s_c4);
         tests_run++; if (s_c4 !== exp_c4) begin tests_failed++; $display("FAIL burst_credit4 cyc %0d got %b want %b", i, s_c4, exp_c4); end
         if (did_deq) begin
            tests_run++; if (s_data !== exp_data) begin tests_failed++; $display("FAIL burst_data cyc %0d got %0d want %0d", i, s_data, exp_data); end
         end
      end
      tests_run++; if (p1 != 8) begin tests_failed++; $display("FAIL burst_pulses got %0d want 8", p1); end
      tests_run++; if (p4 != 2) begin tests_failed++; $display("FAIL burst_pulses4 got %0d want 2", p4); end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_stream();
      test_fill_drain();
      test_overflow();
      test_full_passthrough();
      test_decimation();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
